// File: rtl/pulse_conditioner.sv
// Debounce/synchronize an async pulse line into edge strobes and a clean level.
// Transitions that collapse before being confirmed are tallied as glitches.
module pulse_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       raw_in,
  input  logic       enable_in,
  input  logic       glitch_clr_in,
  output logic       pulse_out,
  output logic       fall_out,
  output logic       level_out,
  output logic [7:0] glitch_cnt_out
);

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOW,
    S_RISE,
    S_HIGH,
    S_FALL
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  sync_q;
  logic        raw_pol;
  logic        s;
  logic        pulse_d, fall_d;
  logic        glitch_inc;

  assign raw_pol = ACTIVE_LOW ? ~raw_in : raw_in;
  assign s       = sync_q[1];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw_pol};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pulse_d    = 1'b0;
    fall_d     = 1'b0;
    glitch_inc = 1'b0;
    if (!enable_in) begin
      state_d = S_LOW;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_LOW: begin
          if (s) begin
            state_d = S_RISE;
            cnt_d   = '0;
          end
        end
        S_RISE: begin
          if (!s) begin
            state_d    = S_LOW;
            glitch_inc = 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_HIGH;
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_HIGH: begin
          if (!s) begin
            state_d = S_FALL;
            cnt_d   = '0;
          end
        end
        S_FALL: begin
          if (s) begin
            state_d    = S_HIGH;
            glitch_inc = 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_LOW;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: begin
          state_d = S_LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= S_LOW;
      cnt_q     <= '0;
      pulse_out <= 1'b0;
      fall_out  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pulse_out <= pulse_d;
      fall_out  <= fall_d;
    end
  end

  // Clear beats a same-cycle increment; count sticks at all-ones.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      glitch_cnt_out <= 8'h00;
    end else if (glitch_clr_in) begin
      glitch_cnt_out <= 8'h00;
    end else if (glitch_inc && glitch_cnt_out != 8'hFF) begin
      glitch_cnt_out <= glitch_cnt_out + 8'd1;
    end
  end

  assign level_out = (state_q == S_HIGH) || (state_q == S_FALL);

endmodule

// File: tb/tb_pulse_conditioner.sv
// Self-checking bench for pulse_conditioner: strobe scoreboard + level checks.
// Three instances: DEBOUNCE 4 / active-high, 4 / active-low, 1 / active-high.
module tb_pulse_conditioner;

  localparam int KP = 1;
  localparam int KF = 2;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       enable_in = 1'b1;
  logic       glitch_clr_in = 1'b0;
  logic [2:0] raw = 3'b010;
  logic [2:0] pulse, fall, level;
  logic [7:0] gcnt [3];

  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  int unsigned sb_q[$];

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  pulse_conditioner #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b0)) u_d0 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .raw_in(raw[0]),
    .enable_in(enable_in), .glitch_clr_in(glitch_clr_in),
    .pulse_out(pulse[0]), .fall_out(fall[0]), .level_out(level[0]),
    .glitch_cnt_out(gcnt[0])
  );

  pulse_conditioner #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)) u_d1 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .raw_in(raw[1]),
    .enable_in(enable_in), .glitch_clr_in(glitch_clr_in),
    .pulse_out(pulse[1]), .fall_out(fall[1]), .level_out(level[1]),
    .glitch_cnt_out(gcnt[1])
  );

  pulse_conditioner #(.DEBOUNCE_CYCLES(1), .ACTIVE_LOW(1'b0)) u_d2 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .raw_in(raw[2]),
    .enable_in(enable_in), .glitch_clr_in(glitch_clr_in),
    .pulse_out(pulse[2]), .fall_out(fall[2]), .level_out(level[2]),
    .glitch_cnt_out(gcnt[2])
  );

  task automatic check(string tag, int unsigned got, int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int unsigned ev(int inst, int kind, int unsigned c);
    return (int'(inst) << 28) | (kind << 24) | (c & 32'h00FF_FFFF);
  endfunction

  task automatic sb_push(int inst, int kind, int unsigned c);
    sb_q.push_back(ev(inst, kind, c));
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic sb_take(int inst, int kind);
    if (sb_q.size() == 0) begin
      check("unexpected_strobe", ev(inst, kind, cyc), 0);
    end else begin
      check("strobe", ev(inst, kind, cyc), sb_q.pop_front());
    end
  endtask

  always @(negedge clk_in) begin
    for (int i = 0; i < 3; i++) begin
      if (pulse[i] && fall[i]) check("both_strobes", 1, 0);
      if (pulse[i]) sb_take(i, KP);
      if (fall[i]) sb_take(i, KF);
    end
  end

  initial begin
    tick(3);
    check("rst_pulse", pulse, 0);
    check("rst_fall", fall, 0);
    check("rst_level", level, 0);
    check("rst_gcnt", gcnt[0], 0);
    rst_n_in = 1'b1;
    tick(2);

    // clean rise and fall, latency DEBOUNCE+2 after the first sampling edge
    raw[0] = 1'b1;
    sb_push(0, KP, cyc + 7);
    tick(20);
    check("level_high", level[0], 1);
    raw[0] = 1'b0;
    sb_push(0, KF, cyc + 7);
    tick(10);
    check("level_low", level[0], 0);
    check("gcnt_clean", gcnt[0], 0);

    // short 2-cycle blip is rejected
    raw[0] = 1'b1;
    tick(2);
    raw[0] = 1'b0;
    tick(8);
    check("blip_level", level[0], 0);
    check("blip_gcnt", gcnt[0], 1);

    glitch_clr_in = 1'b1;
    tick(1);
    glitch_clr_in = 1'b0;
    check("clr_gcnt", gcnt[0], 0);

    // bounce 1,0,1,0,1 then hold high
    for (int i = 0; i < 5; i++) begin
      raw[0] = (i % 2 == 0);
      if (i == 4) sb_push(0, KP, cyc + 7);
      tick(1);
    end
    tick(12);
    check("bounce_gcnt", gcnt[0], 2);
    check("bounce_level", level[0], 1);
    raw[0] = 1'b0;
    sb_push(0, KF, cyc + 7);
    tick(10);

    // saturation
    for (int i = 0; i < 300; i++) begin
      raw[0] = 1'b1;
      tick(1);
      raw[0] = 1'b0;
      tick(1);
    end
    tick(5);
    check("sat_gcnt", gcnt[0], 8'hFF);

    // clear coincident with the glitch increment (from 255, then from 0)
    for (int k = 0; k < 2; k++) begin
      raw[0] = 1'b1;
      tick(1);
      raw[0] = 1'b0;
      tick(2);
      glitch_clr_in = 1'b1;
      tick(1);
      glitch_clr_in = 1'b0;
      check("clr_wins", gcnt[0], 0);
      tick(4);
    end
    check("clr_hold", gcnt[0], 0);

    // reset mid-debounce aborts; fresh debounce after release
    raw[0] = 1'b1;
    tick(4);
    rst_n_in = 1'b0;
    #1;
    check("midrst_pulse", pulse, 0);
    check("midrst_level", level, 0);
    tick(2);
    rst_n_in = 1'b1;
    sb_push(0, KP, cyc + 7);
    tick(12);
    check("postrst_level", level[0], 1);
    raw[0] = 1'b0;
    sb_push(0, KF, cyc + 7);
    tick(10);

    // DEBOUNCE_CYCLES = 1
    raw[2] = 1'b1;
    sb_push(2, KP, cyc + 4);
    tick(8);
    check("d1_level", level[2], 1);
    raw[2] = 1'b0;
    sb_push(2, KF, cyc + 4);
    tick(8);
    check("d1_level_low", level[2], 0);

    // active-low instance, then enable drop while high
    raw[1] = 1'b0;
    sb_push(1, KP, cyc + 7);
    tick(10);
    check("al_level", level[1], 1);
    enable_in = 1'b0;
    tick(1);
    check("en_drop_level", level[1], 0);
    tick(10);
    check("en_off_level", level[1], 0);

    // enable back with input still active: fresh debounce from S_LOW
    enable_in = 1'b1;
    sb_push(1, KP, cyc + 5);
    tick(10);
    check("reen_level", level[1], 1);
    raw[1] = 1'b1;
    sb_push(1, KF, cyc + 7);
    tick(10);
    check("al_level_low", level[1], 0);
    check("al_gcnt", gcnt[1], 0);

    check("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
